// File: rtl/fifo_thresh_pkg.sv
// Shared helpers for the fifo_thresh slice: register-delay macro and width functions.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
`ifndef FIFO_THRESH_TD_DEFINED
`define FIFO_THRESH_TD_DEFINED
// Register delay for sequential assignments; empty so synthesis and simulation agree.
`define TD
`endif

package fifo_thresh_pkg;

    // Pointer width; at least one bit even for degenerate depths.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy width: must be able to hold the value DEPTH itself.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_thresh_if.sv
// Producer/consumer valid-ready bundle for fifo_thresh.
// Latency: n/a (wiring only).
// Backpressure: input_ready from the FIFO, output_ready from the consumer.
interface fifo_thresh_if
    import fifo_thresh_pkg::*;
#(
    parameter int W = 8
);
    logic         input_valid;
    logic [W-1:0] input_payload;
    logic         input_ready;
    logic         output_valid;
    logic [W-1:0] output_payload;
    logic         output_ready;

    // Side that feeds and drains the FIFO (producer + consumer stages).
    modport master (
        output input_valid,
        output input_payload,
        output output_ready,
        input  input_ready,
        input  output_valid,
        input  output_payload
    );

    // The FIFO itself.
    modport slave (
        input  input_valid,
        input  input_payload,
        input  output_ready,
        output input_ready,
        output output_valid,
        output output_payload
    );
endinterface

// File: rtl/fifo_ptr_wrap.sv
// Next-pointer for a circular buffer of arbitrary (non-power-of-two) depth.
// Latency: combinational.
// Backpressure: none; caller decides when to advance.
module fifo_ptr_wrap
    import fifo_thresh_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic [AW-1:0] ptr,
    output logic [AW-1:0] ptr_nxt
);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    // Wrap at DEPTH-1 explicitly; binary overflow only matches power-of-two depths.
    always_comb begin
        ptr_nxt = (ptr == LAST) ? '0 : ptr + AW'(1);
    end
endmodule

// File: rtl/fifo_thresh.sv
// Valid/ready FIFO with occupancy count, almost-full/empty flags and sync flush.
// Latency: 1 cycle push-to-output; 0 cycles on empty when FIFO_THRESH_BYPASS_EN is defined.
// Backpressure: input_ready = !full && !flush, independent of output_ready.
module fifo_thresh
    import fifo_thresh_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int W             = 8,
    parameter int AFULL_THRESH  = DEPTH - 1,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    fifo_thresh_if.slave                  bus,
    output logic [count_width(DEPTH)-1:0] count,
    output logic                          almost_full,
    output logic                          almost_empty
);
    localparam int ADDR_WIDTH  = addr_width(DEPTH);
    localparam int COUNT_WIDTH = count_width(DEPTH);

    localparam logic [COUNT_WIDTH-1:0] DEPTH_C  = COUNT_WIDTH'(DEPTH);
    localparam logic [COUNT_WIDTH-1:0] AFULL_C  = COUNT_WIDTH'(AFULL_THRESH);
    localparam logic [COUNT_WIDTH-1:0] AEMPTY_C = COUNT_WIDTH'(AEMPTY_THRESH);
    localparam logic [COUNT_WIDTH-1:0] ONE_C    = COUNT_WIDTH'(1);

    logic [W-1:0]           mem [DEPTH];
    logic [ADDR_WIDTH-1:0]  head_ptr;
    logic [ADDR_WIDTH-1:0]  tail_ptr;
    logic [ADDR_WIDTH-1:0]  head_nxt;
    logic [ADDR_WIDTH-1:0]  tail_nxt;
    logic [COUNT_WIDTH-1:0] count_q;

    logic push;      // handshake on the input side
    logic pop;       // handshake on the output side
    logic push_st;   // push that lands in storage
    logic pop_st;    // pop that drains storage

    fifo_ptr_wrap #(.DEPTH(DEPTH), .AW(ADDR_WIDTH)) u_head_wrap (
        .ptr     (head_ptr),
        .ptr_nxt (head_nxt)
    );

    fifo_ptr_wrap #(.DEPTH(DEPTH), .AW(ADDR_WIDTH)) u_tail_wrap (
        .ptr     (tail_ptr),
        .ptr_nxt (tail_nxt)
    );

    // Accept only with a free slot; a same-cycle pop never frees room for a full FIFO.
    always_comb begin
        bus.input_ready = (count_q < DEPTH_C) && !flush;
    end

`ifdef FIFO_THRESH_BYPASS_EN
    logic byp;

    // Empty FIFO forwards the producer word straight through.
    always_comb begin
        byp                = (count_q == '0) && bus.input_valid && !flush;
        bus.output_valid   = byp || ((count_q != '0) && !flush);
        bus.output_payload = byp ? bus.input_payload : mem[head_ptr];
    end

    // A bypassed word taken by the consumer never touches storage or pointers.
    always_comb begin
        push    = bus.input_valid && bus.input_ready;
        pop     = bus.output_valid && bus.output_ready;
        push_st = push && !(byp && bus.output_ready);
        pop_st  = pop && !byp;
    end
`else
    // Head entry is presented whenever storage is non-empty and no flush is in progress.
    always_comb begin
        bus.output_valid   = (count_q != '0) && !flush;
        bus.output_payload = mem[head_ptr];
    end

    // Every handshake maps directly onto storage.
    always_comb begin
        push    = bus.input_valid && bus.input_ready;
        pop     = bus.output_valid && bus.output_ready;
        push_st = push;
        pop_st  = pop;
    end
`endif

    // Storage write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (push_st) begin
            mem[tail_ptr] <= `TD bus.input_payload;
        end
    end

    // Pointer and occupancy update; reset beats flush, flush beats traffic.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            head_ptr <= `TD '0;
            tail_ptr <= `TD '0;
            count_q  <= `TD '0;
        end else begin
            if (push_st) begin
                tail_ptr <= `TD tail_nxt;
            end
            if (pop_st) begin
                head_ptr <= `TD head_nxt;
            end
            case ({push_st, pop_st})
                2'b10:   count_q <= `TD count_q + ONE_C;
                2'b01:   count_q <= `TD count_q - ONE_C;
                default: count_q <= `TD count_q;
            endcase
        end
    end

    // Flags decode the registered count so they never see same-cycle traffic.
    always_comb begin
        count        = count_q;
        almost_full  = (count_q >= AFULL_C);
        almost_empty = (count_q <= AEMPTY_C);
    end
endmodule

// File: tb/tb_fifo_thresh.sv
// Self-checking bench for fifo_thresh: directed scenarios plus random traffic against a queue model.
// Latency: checks 1-cycle push-to-output (0 on empty with FIFO_THRESH_BYPASS_EN).
// Backpressure: drives random output_ready and flush; checks input_ready against the model.
module tb_fifo_thresh;
    localparam int DEPTH = 5;
    localparam int W     = 8;
    localparam int AF    = 3;
    localparam int AE    = 1;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic [2:0]   count;
    logic         almost_full;
    logic         almost_empty;

    fifo_thresh_if #(.W(W)) bus ();

    fifo_thresh #(
        .DEPTH         (DEPTH),
        .W             (W),
        .AFULL_THRESH  (AF),
        .AEMPTY_THRESH (AE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .bus          (bus),
        .count        (count),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
    );

    always #5 clk = ~clk;

    // Reference model: the ordered list of words the FIFO should hold.
    logic [W-1:0] exp_q[$];
    int           vectors    = 0;
    int           miscompares = 0;
    bit           mon_en     = 1'b0;
    bit           byp_taken  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: compares DUT outputs against the model mid-cycle and retires popped words.
    always @(negedge clk) begin
        int           n;
        bit           ev;
        bit           er;
        logic [W-1:0] ep;
        #2;
        if (mon_en) begin
            n  = exp_q.size();
            er = (n < DEPTH) && !flush;
            ev = (n > 0) && !flush;
            ep = (n > 0) ? exp_q[0] : '0;
            byp_taken = 1'b0;
`ifdef FIFO_THRESH_BYPASS_EN
            if (n == 0 && bus.input_valid && !flush) begin
                ev        = 1'b1;
                ep        = bus.input_payload;
                byp_taken = bus.output_ready;
            end
`endif
            chk("count",        32'(count),            32'(n));
            chk("input_ready",  32'(bus.input_ready),  32'(er));
            chk("output_valid", 32'(bus.output_valid), 32'(ev));
            chk("almost_full",  32'(almost_full),      32'(n >= AF));
            chk("almost_empty", 32'(almost_empty),     32'(n <= AE));
            if (ev && bus.output_ready) begin
                chk("payload", 32'(bus.output_payload), 32'(ep));
                if (!byp_taken) void'(exp_q.pop_front());
            end
        end
    end

    // One clock of stimulus; the accepted word enters the model after the monitor has run.
    task automatic cycle(input logic iv, input logic [W-1:0] d, input logic ordy, input logic fl);
        bit will_push;
        @(negedge clk);
        bus.input_valid   = iv;
        bus.input_payload = d;
        bus.output_ready  = ordy;
        flush             = fl;
        #1;
        will_push = iv && !fl && (exp_q.size() < DEPTH);
        #2;
        if (fl) exp_q.delete();
        else if (will_push && !byp_taken) exp_q.push_back(d);
    endtask

    task automatic idle_inputs();
        bus.input_valid   = 1'b0;
        bus.input_payload = '0;
        bus.output_ready  = 1'b0;
        flush             = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_count"},        32'(count),            32'd0);
        chk({tag, "_input_ready"},  32'(bus.input_ready),  32'd1);
        chk({tag, "_output_valid"}, 32'(bus.output_valid), 32'd0);
        chk({tag, "_almost_full"},  32'(almost_full),      32'd0);
        chk({tag, "_almost_empty"}, 32'(almost_empty),     32'd1);
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2 check_reset_state("reset");
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Fill to full, then one rejected push, then drain in order.
        for (int i = 1; i <= DEPTH; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
        cycle(1'b1, 8'h66, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);

        // Interleaved traffic to wrap both pointers past the last index.
        for (int i = 0; i < 12; i++) cycle(1'b1, 8'(8'h10 + i), (i % 3) != 0, 1'b0);
        for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Simultaneous push and pop at count 3.
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
        cycle(1'b1, 8'h33, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);

        // Top up to 4, then flush with a competing push.
        cycle(1'b1, 8'h34, 1'b0, 1'b0);
        cycle(1'b1, 8'hEE, 1'b1, 1'b1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Flag sweep 0 -> 4 -> 0.
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Empty-FIFO push with and without a ready consumer.
        cycle(1'b1, 8'hA5, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        cycle(1'b1, 8'hA5, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 24) == 0);
        end

        // Reset with contents in flight discards everything.
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
        @(negedge clk);
        mon_en = 1'b0;
        rst_n  = 1'b0;
        bus.input_valid  = 1'b1;
        bus.output_ready = 1'b1;
        @(negedge clk);
        idle_inputs();
        #2 check_reset_state("midreset");
        exp_q.delete();
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < 30; i++) cycle($urandom_range(0, 1) != 0, 8'($urandom), $urandom_range(0, 1) != 0, 1'b0);
        for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

        @(negedge clk);
        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fifo_thresh.md
Name: fifo_thresh

Overview:
Parametrised valid/ready FIFO for the compression datapath. It adds the following:
- non-power-of-two depth support;
- occupancy count output;
- programmable almost-full and almost-empty flags;
- synchronous flush.
It sits between producer and consumer stages that need early back-pressure (e.g. hash/match pipelines). An optional compile-time bypass gives zero-latency fall-through when the FIFO is empty.

Parameters:
DEPTH, 4, number of entries; any integer >= 2, need not be a power of two
W, 8, payload width in bits
AFULL_THRESH, DEPTH-1, almost_full asserted when count >= AFULL_THRESH; legal range 1..DEPTH
AEMPTY_THRESH, 1, almost_empty asserted when count <= AEMPTY_THRESH; legal range 0..DEPTH-1

Ports:
clk  input  1  clock
rst_n  input  1  reset, synchronous, active-low
flush  input  1  synchronous clear of all contents
input_valid  input  1  producer has data
input_payload  input  W  producer data
input_ready  output  1  FIFO can accept
output_valid  output  1  head entry available
output_payload  output  W  head entry data
output_ready  input  1  consumer accepts
count  output  $clog2(DEPTH+1)  current occupancy
almost_full  output  1  count >= AFULL_THRESH
almost_empty  output  1  count <= AEMPTY_THRESH

Behaviour:
- Reset (rst_n=0 at posedge clk) values:
  - head_ptr=0, tail_ptr=0, count=0;
  - input_ready=1, output_valid=0, almost_full=0 (given AFULL_THRESH>=1), almost_empty=1.
  - Storage array is not reset; output_payload is don't-care while output_valid=0.
- Push fires when input_valid && input_ready. Pop fires when output_valid && output_ready.
- input_ready = (count < DEPTH) && !flush.
  - A full FIFO does not accept a push even if a pop happens in the same cycle; input_ready never depends on output_ready.
- output_valid = (count > 0) && !flush (non-bypass build).
- output_payload = mem[head_ptr].
- Latency: a word pushed at edge t is visible at the output (output_valid=1) in the cycle after edge t.
- Pointer increment wraps explicitly: ptr == DEPTH-1 -> 0, else ptr+1. No reliance on power-of-two overflow.
- Count update:
  - push only: +1;
  - pop only: -1;
  - push and pop together: unchanged, both pointers advance;
  - neither: hold.
- Flush, sampled at posedge:
  - head_ptr, tail_ptr and count go to 0 at the next edge;
  - takes priority over push and pop in the same cycle;
  - input_ready and output_valid are forced 0 during the flush cycle, so no transfer completes.
- Reset has priority over flush. Reset mid-operation discards all contents, with no partial pop.
- Flags:
  - almost_full and almost_empty are combinational from the count register, so they are valid from the cycle after the count change.
  - The count output equals the count register.
- Ordering: strict FIFO. Data is never overwritten while count==DEPTH.

Optional Feature:
Macro FIFO_THRESH_BYPASS_EN.
- Defined: when count==0 && input_valid && !flush:
  - output_valid=1 and output_payload=input_payload combinationally;
  - if output_ready=1, the word transfers in the same cycle; count and pointers stay unchanged and the word is not written to storage;
  - if output_ready=0, the word is written normally.
- Not defined: no combinational input-to-output path. Behaviour is exactly as described above, with output_valid depending only on count and flush.

Decomposition:
- Shared util header supplies the `TD` register delay macro. No other typedefs are needed.
- ADDR_WIDTH ($clog2(DEPTH)) and COUNT_WIDTH ($clog2(DEPTH+1)) are local parameters.
- One sub-module is natural: fifo_ptr_wrap, a combinational next-pointer with non-power-of-two wrap. It is instantiated for head and tail.

Test Plan:
- DEPTH=5, W=8: push 0x01..0x05 with no pop -> input_ready=0 after the 5th push, count=5, almost_full=1. Then pop 5 -> data 0x01..0x05 in order, count=0, almost_empty=1.
- DEPTH=5: 12 pushes interleaved with pops to force pointer wrap past index 4 -> output sequence equals input sequence, count never exceeds 5.
- count=3, push and pop in the same cycle -> count stays 3, head and tail both advance, popped word is the oldest.
- count=4 with flush=1 and input_valid=1 in the same cycle -> no transfer that cycle, count=0 next cycle, output_valid=0, the pushed word is discarded.
- AFULL_THRESH=3, AEMPTY_THRESH=1: step count 0->4->0 -> almost_full high exactly at count 3 and 4; almost_empty high exactly at count 0 and 1.
- FIFO_THRESH_BYPASS_EN defined, empty FIFO: push 0xA5 with output_ready=1 -> output_valid=1 and payload 0xA5 in the same cycle, count stays 0. Same push with output_ready=0 -> count=1 next cycle.
